// File: rtl/multi_phase_intersection.sv
// multi_phase_intersection
// Round-robin N-phase traffic signal controller. Each phase is served with
// green, then yellow, then an all-red clearance. A latched pedestrian request
// extends that phase's next green and lights its walk lamp for the whole green.
// All lamp outputs are registered and follow the state one clock later.

module multi_phase_intersection #(
    parameter int N_PHASES = 4,
    parameter int CNT_W    = 8,
    parameter int GRN_TON  = 20,
    parameter int YLW_TON  = 3,
    parameter int RED_TON  = 2,
    parameter int WALK_EXT = 10,
    parameter int PRESCALE = 1,
    localparam int PH_W    = $clog2(N_PHASES)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_PHASES-1:0] cross_btn,
    output logic [N_PHASES-1:0] red,
    output logic [N_PHASES-1:0] ylw,
    output logic [N_PHASES-1:0] grn,
    output logic [N_PHASES-1:0] walk,
    output logic [N_PHASES-1:0] stop,
    output logic [PH_W-1:0]     phase_idx,
    output logic                fault
);

    // Prescaler width; a prescale of 1 still gets a one-bit counter that
    // stays at zero so that every clock is a tick.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PS_W-1:0]  PS_LAST      = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] GRN_LAST     = CNT_W'(GRN_TON - 1);
    localparam logic [CNT_W-1:0] GRN_EXT_LAST = CNT_W'(GRN_TON + WALK_EXT - 1);
    localparam logic [CNT_W-1:0] YLW_LAST     = CNT_W'(YLW_TON - 1);
    localparam logic [CNT_W-1:0] RED_LAST     = CNT_W'(RED_TON - 1);
    localparam logic [PH_W-1:0]  PH_LAST      = PH_W'(N_PHASES - 1);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_GRN  = 3'd1,
        ST_YLW  = 3'd2,
        ST_CLR  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Sequencing state
    state_t              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [PS_W-1:0]     presc_q, presc_d;
    logic [N_PHASES-1:0] req_q, req_d;
    logic                ext_q, ext_d;

    // Registered outputs
    logic [N_PHASES-1:0] red_q, red_d;
    logic [N_PHASES-1:0] ylw_q, ylw_d;
    logic [N_PHASES-1:0] grn_q, grn_d;
    logic [N_PHASES-1:0] walk_q, walk_d;
    logic [N_PHASES-1:0] stop_q, stop_d;
    logic [PH_W-1:0]     phase_idx_q, phase_idx_d;
    logic                fault_q, fault_d;

    // Combinational helpers
    logic                tick;
    logic                done;
    logic                enter_grn;
    logic [CNT_W-1:0]    last;
    logic [N_PHASES-1:0] onehot;

    assign tick = (presc_q == PS_LAST);

    // Prescaler: free-running divider whose terminal count is the tick.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Next-state logic: timer, phase rotation and pedestrian request latching.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        timer_d   = timer_q;
        ext_d     = ext_q;
        req_d     = req_q | ~cross_btn;
        enter_grn = 1'b0;
        last      = '0;

        case (state_q)
            ST_INIT: last = RED_LAST;
            ST_GRN:  last = ext_q ? GRN_EXT_LAST : GRN_LAST;
            ST_YLW:  last = YLW_LAST;
            ST_CLR:  last = RED_LAST;
            default: last = '0;
        endcase

        done = tick && (timer_q == last);

        if (tick) begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            ST_INIT: begin
                if (done) begin
                    state_d   = ST_GRN;
                    phase_d   = '0;
                    timer_d   = '0;
                    enter_grn = 1'b1;
                end
            end
            ST_GRN: begin
                if (done) begin
                    state_d = ST_YLW;
                    timer_d = '0;
                    ext_d   = 1'b0;
                end
            end
            ST_YLW: begin
                if (done) begin
                    state_d = ST_CLR;
                    timer_d = '0;
                end
            end
            ST_CLR: begin
                if (done) begin
                    state_d   = ST_GRN;
                    phase_d   = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
                    timer_d   = '0;
                    enter_grn = 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_INIT;
                phase_d = '0;
                timer_d = '0;
                ext_d   = 1'b0;
            end
            default: begin
                state_d = ST_ERR;
                timer_d = '0;
                ext_d   = 1'b0;
            end
        endcase

        // A request latched earlier or a press on the entry clock itself
        // extends the green being entered; the request is consumed here.
        if (enter_grn) begin
            ext_d          = req_q[phase_d] | ~cross_btn[phase_d];
            req_d[phase_d] = 1'b0;
        end
    end

    // Lamp decode from the current state; registered so lamps lag by a clock.
    always_comb begin
        onehot      = {{(N_PHASES-1){1'b0}}, 1'b1} << phase_q;
        red_d       = '0;
        ylw_d       = '0;
        grn_d       = '0;
        walk_d      = '0;
        stop_d      = '0;
        fault_d     = fault_q;
        phase_idx_d = phase_q;

        case (state_q)
            ST_INIT, ST_CLR: begin
                red_d  = '1;
                stop_d = '1;
            end
            ST_GRN: begin
                grn_d  = onehot;
                red_d  = ~onehot;
                walk_d = ext_q ? onehot : '0;
                stop_d = ~walk_d;
            end
            ST_YLW: begin
                ylw_d  = onehot;
                red_d  = ~onehot;
                stop_d = '1;
            end
            default: begin
                red_d   = '1;
                ylw_d   = '1;
                grn_d   = '1;
                walk_d  = '1;
                stop_d  = '1;
                fault_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            phase_q     <= '0;
            timer_q     <= '0;
            presc_q     <= '0;
            req_q       <= '0;
            ext_q       <= 1'b0;
            red_q       <= '0;
            ylw_q       <= '0;
            grn_q       <= '0;
            walk_q      <= '0;
            stop_q      <= '0;
            phase_idx_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            timer_q     <= timer_d;
            presc_q     <= presc_d;
            req_q       <= req_d;
            ext_q       <= ext_d;
            red_q       <= red_d;
            ylw_q       <= ylw_d;
            grn_q       <= grn_d;
            walk_q      <= walk_d;
            stop_q      <= stop_d;
            phase_idx_q <= phase_idx_d;
            fault_q     <= fault_d;
        end
    end

    assign red       = red_q;
    assign ylw       = ylw_q;
    assign grn       = grn_q;
    assign walk      = walk_q;
    assign stop      = stop_q;
    assign phase_idx = phase_idx_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_multi_phase_intersection.sv
// Testbench for multi_phase_intersection.
// Two instances: the default 4-phase controller driven with pedestrian presses
// and a mid-yellow reset, and a 2-phase controller with a prescale of 4.
// Outputs are seen as a sequence of constant segments (lamp pattern plus its
// length in clocks); expected segments are queued as stimulus is issued and a
// monitor per instance pops and compares each segment when it ends.

module tb_multi_phase_intersection;

    localparam int K_DARK = 0;
    localparam int K_RED  = 1;
    localparam int K_GRN  = 2;
    localparam int K_YLW  = 3;

    typedef struct packed {
        logic [7:0]  red;
        logic [7:0]  ylw;
        logic [7:0]  grn;
        logic [7:0]  walk;
        logic [7:0]  stop;
        logic [2:0]  ph;
        logic        flt;
        logic [15:0] len;
    } seg_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       resetNB;
    logic [3:0] crossBtn;

    logic [3:0] redA, ylwA, grnA, walkA, stopA;
    logic [1:0] phaseA;
    logic       faultA;

    logic [1:0] redB, ylwB, grnB, walkB, stopB;
    logic       phaseB;
    logic       faultB;

    seg_t expA[$];
    seg_t expB[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cur         = 0;
    bit   monEn       = 1'b0;

    always #5 clk = ~clk;

    multi_phase_intersection dutA (
        .clk       (clk),
        .reset_n   (resetN),
        .cross_btn (crossBtn),
        .red       (redA),
        .ylw       (ylwA),
        .grn       (grnA),
        .walk      (walkA),
        .stop      (stopA),
        .phase_idx (phaseA),
        .fault     (faultA)
    );

    multi_phase_intersection #(
        .N_PHASES (2),
        .PRESCALE (4)
    ) dutB (
        .clk       (clk),
        .reset_n   (resetNB),
        .cross_btn (2'b11),
        .red       (redB),
        .ylw       (ylwB),
        .grn       (grnB),
        .walk      (walkB),
        .stop      (stopB),
        .phase_idx (phaseB),
        .fault     (faultB)
    );

    function automatic seg_t mkSeg(input int kind, input int p, input bit ext,
                                   input int nph, input int len);
        seg_t       s;
        logic [7:0] mask;
        logic [7:0] one;
        mask  = 8'((1 << nph) - 1);
        one   = 8'(1 << p);
        s     = '0;
        s.len = 16'(len);
        s.ph  = 3'(p);
        case (kind)
            K_RED: begin
                s.red  = mask;
                s.stop = mask;
            end
            K_GRN: begin
                s.grn  = one;
                s.red  = mask & ~one;
                s.walk = ext ? one : 8'h00;
                s.stop = mask & ~s.walk;
            end
            K_YLW: begin
                s.ylw  = one;
                s.red  = mask & ~one;
                s.stop = mask;
            end
            default: s = s;
        endcase
        return s;
    endfunction

    function automatic string fmtSeg(input seg_t s);
        return $sformatf("red=%h ylw=%h grn=%h walk=%h stop=%h ph=%0d flt=%b len=%0d",
                         s.red, s.ylw, s.grn, s.walk, s.stop, s.ph, s.flt, s.len);
    endfunction

    task automatic pushSeg(input int which, input seg_t s);
        if (which == 0) expA.push_back(s);
        else            expB.push_back(s);
    endtask

    task automatic pushService(input int which, input int p, input bit ext, input int nph,
                               input int gLen, input int yLen, input int rLen);
        pushSeg(which, mkSeg(K_GRN, p, ext, nph, gLen));
        pushSeg(which, mkSeg(K_YLW, p, 1'b0, nph, yLen));
        pushSeg(which, mkSeg(K_RED, p, 1'b0, nph, rLen));
    endtask

    task automatic pushRoundA(input logic [3:0] extMask);
        for (int p = 0; p < 4; p++) begin
            pushService(0, p, extMask[p], 4, extMask[p] ? 30 : 20, 3, 2);
        end
    endtask

    // Pop the next expected segment of an instance and compare a finished one.
    task automatic checkOutput(input int which, input seg_t act);
        seg_t  expd;
        string nm;
        nm = (which == 0) ? "dutA" : "dutB";
        vectors++;
        if ((which == 0 && expA.size() == 0) || (which == 1 && expB.size() == 0)) begin
            miscompares++;
            $display("[TB] FAIL %s segment #%0d: actual %s, required none", nm, vectors, fmtSeg(act));
        end else begin
            expd = (which == 0) ? expA.pop_front() : expB.pop_front();
            if (act !== expd) begin
                miscompares++;
                $display("[TB] FAIL %s segment #%0d: actual %s, required %s",
                         nm, vectors, fmtSeg(act), fmtSeg(expd));
            end
        end
    endtask

    task automatic stepTo(input int k);
        while (cur < k) begin
            @(posedge clk);
            cur++;
        end
        #1;
    endtask

    task automatic applyStimulus(input int at, input logic [3:0] btn, input logic rst);
        stepTo(at);
        crossBtn = btn;
        resetN   = rst;
    endtask

    // Monitor for the 4-phase instance: closes a segment on any output change.
    seg_t curA, prevA;
    bit   haveA = 1'b0;
    int   lenA  = 0;
    always @(negedge clk) begin
        if (monEn) begin
            curA           = '0;
            curA.red[3:0]  = redA;
            curA.ylw[3:0]  = ylwA;
            curA.grn[3:0]  = grnA;
            curA.walk[3:0] = walkA;
            curA.stop[3:0] = stopA;
            curA.ph[1:0]   = phaseA;
            curA.flt       = faultA;
            if (!haveA) begin
                prevA = curA;
                lenA  = 1;
                haveA = 1'b1;
            end else if (curA === prevA) begin
                lenA++;
            end else begin
                prevA.len = 16'(lenA);
                checkOutput(0, prevA);
                prevA = curA;
                lenA  = 1;
            end
        end
    end

    // Monitor for the 2-phase prescaled instance.
    seg_t curB, prevB;
    bit   haveB = 1'b0;
    int   lenB  = 0;
    always @(negedge clk) begin
        if (monEn) begin
            curB           = '0;
            curB.red[1:0]  = redB;
            curB.ylw[1:0]  = ylwB;
            curB.grn[1:0]  = grnB;
            curB.walk[1:0] = walkB;
            curB.stop[1:0] = stopB;
            curB.ph[0]     = phaseB;
            curB.flt       = faultB;
            if (!haveB) begin
                prevB = curB;
                lenB  = 1;
                haveB = 1'b1;
            end else if (curB === prevB) begin
                lenB++;
            end else begin
                prevB.len = 16'(lenB);
                checkOutput(1, prevB);
                prevB = curB;
                lenB  = 1;
            end
        end
    end

    // Directed scenario; edge numbers count clocks after reset release.
    initial begin
        seg_t leftover;
        resetN   = 1'b0;
        resetNB  = 1'b0;
        crossBtn = 4'hF;

        @(posedge clk);
        #1;
        monEn = 1'b1;

        // Three reset clocks dark, INIT all red, then the first round.
        pushSeg(0, mkSeg(K_DARK, 0, 1'b0, 4, 3));
        pushSeg(0, mkSeg(K_RED, 0, 1'b0, 4, 2));
        pushRoundA(4'b0000);

        // Prescaled 2-phase instance: INIT 8, green 80, yellow 12, clear 8.
        pushSeg(1, mkSeg(K_DARK, 0, 1'b0, 2, 3));
        pushSeg(1, mkSeg(K_RED, 0, 1'b0, 2, 8));
        for (int r = 0; r < 2; r++) begin
            pushService(1, 0, 1'b0, 2, 80, 12, 8);
            pushService(1, 1, 1'b0, 2, 80, 12, 8);
        end
        pushSeg(1, mkSeg(K_GRN, 0, 1'b0, 2, 80));

        repeat (2) @(posedge clk);
        #1;
        resetN  = 1'b1;
        resetNB = 1'b1;
        cur     = 0;

        // Round 2: phase 2 request during phase 0 green, phase 0 own press.
        applyStimulus(100, 4'hF, 1'b1);
        $display("[TB] round 2: presses on phase 2 and own phase 0");
        pushRoundA(4'b0100);
        applyStimulus(110, 4'b1011, 1'b1);
        applyStimulus(111, 4'hF, 1'b1);
        applyStimulus(115, 4'b1110, 1'b1);
        applyStimulus(116, 4'hF, 1'b1);

        // Round 3: phase 0 extended; phase 1 pressed only on its entry clock.
        applyStimulus(200, 4'hF, 1'b1);
        $display("[TB] round 3: press on phase 1 entry clock");
        pushRoundA(4'b0011);
        applyStimulus(246, 4'b1101, 1'b1);
        applyStimulus(247, 4'hF, 1'b1);

        // Round 4: phase 3 request pending, reset one clock into YLW(1).
        applyStimulus(330, 4'hF, 1'b1);
        $display("[TB] round 4: reset mid yellow with phase 3 pending");
        pushService(0, 0, 1'b0, 4, 20, 3, 2);
        pushSeg(0, mkSeg(K_GRN, 1, 1'b0, 4, 20));
        pushSeg(0, mkSeg(K_YLW, 1, 1'b0, 4, 1));
        pushSeg(0, mkSeg(K_DARK, 0, 1'b0, 4, 1));
        pushSeg(0, mkSeg(K_RED, 0, 1'b0, 4, 2));
        pushRoundA(4'b0000);
        applyStimulus(365, 4'b0111, 1'b1);
        applyStimulus(366, 4'hF, 1'b1);
        applyStimulus(378, 4'hF, 1'b0);
        applyStimulus(379, 4'hF, 1'b1);

        stepTo(492);
        monEn = 1'b0;

        while (expA.size() > 0) begin
            leftover = expA.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL dutA missing segment: actual none, required %s", fmtSeg(leftover));
        end
        while (expB.size() > 0) begin
            leftover = expB.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL dutB missing segment: actual none, required %s", fmtSeg(leftover));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_phase_intersection.md
Name: multi_phase_intersection

Overview:
- Parametrised N-phase traffic signal controller. Serves N_PHASES approaches in round-robin order: green, then yellow, then all-red clearance for each.
- Each phase has an active-low pedestrian button. A latched request extends that phase's next green and drives its walk lamp.
- Successor to the fixed two-way controller. Used as the per-intersection core under the board top level.

Parameters:
N_PHASES, 4, number of approaches/phases (2..8)
CNT_W, 8, tick timer width; must hold GRN_TON+WALK_EXT-1
GRN_TON, 20, base green duration in ticks
YLW_TON, 3, yellow duration in ticks
RED_TON, 2, all-red clearance (and INIT) duration in ticks
WALK_EXT, 10, extra green ticks when a pedestrian request is served
PRESCALE, 1, clk cycles per tick (1 = every clock)

Ports:
clk  input  1  clock; all logic on posedge
reset_n  input  1  synchronous, active-low reset
cross_btn  input  N_PHASES  pedestrian buttons, active-low, one per phase, already synchronised
red  output  N_PHASES  red lamp per phase
ylw  output  N_PHASES  yellow lamp per phase
grn  output  N_PHASES  green lamp per phase
walk  output  N_PHASES  walk lamp per phase
stop  output  N_PHASES  don't-walk lamp per phase
phase_idx  output  clog2(N_PHASES)  phase currently served
fault  output  1  sticky illegal-state flag

Behaviour:
- Reset: one clock, synchronous, active-low; reset polarity and synchronicity are fixed.
  - If reset_n is low at a clk edge, on that edge: all lamps go to 0, phase_idx=0, fault=0, pending requests clear, prescaler and timer clear, state=INIT.
  - Reset mid-operation has the same effect from any state.
- Tick: prescaler counts 0..PRESCALE-1. tick=1 on the terminal count, i.e. every PRESCALE clocks. The timer advances only on tick.
- States: INIT, GRN, YLW, CLR, ERR. Each state lasts exactly its duration in ticks. The timer clears on every state change.
  - INIT: all red, all stop, for RED_TON ticks. Then GRN with phase 0.
  - GRN(p): grn[p]=1; every other phase red. Lasts GRN_TON ticks, or GRN_TON+WALK_EXT if extended. Then YLW.
  - YLW(p): ylw[p]=1; every other phase red. Lasts YLW_TON ticks. Then CLR.
  - CLR: all red for RED_TON ticks. Then GRN with p=(p+1) mod N_PHASES (wraps N_PHASES-1 -> 0).
  - ERR: any illegal state encoding. All lamps and walk set to 1, fault=1. Next clock goes to INIT. fault holds until reset.
- Outputs: all registered; lamp outputs change on the clock edge after the state change.
- Requests:
  - A clock with cross_btn[i]==0 sets req[i]; req[i] stays set until served.
  - On entry to GRN(p): if req[p], or cross_btn[p]==0 on the entry clock, then extended=1, walk[p]=1 and stop[p]=0 for the whole green, and req[p] clears on that edge.
  - A press during phase p's own GRN/YLW/CLR sets req[p] for the next service. It never alters the current green.
- walk/stop:
  - walk[p]=0 and stop[p]=1 whenever phase p is not in an extended green. This includes INIT, YLW and CLR.
  - walk and stop are never both 1 except in ERR.
- Lamp invariants, outside reset and ERR: exactly one of red/ylw/grn is 1 per phase; at most one phase is non-red.
- Period with no requests = N_PHASES*(GRN_TON+YLW_TON+RED_TON) ticks.

Test Plan:
1. Defaults, reset_n released, no presses.
   - After 1 clock: all red, stop=1111.
   - grn[0] rises 2 clocks later, high 20 clocks; ylw[0] high 3 clocks; all red 2 clocks.
   - grn[1] follows; grn[0] next rises 100 clocks after its first rise.
2. cross_btn[2] low for 1 clock during phase 0 green.
   - Phase 2 green lasts 30 clocks with walk[2]=1, stop[2]=0 throughout.
   - Phase 2's following green lasts 20 clocks.
3. cross_btn[0] low during phase 0 green.
   - Current green is still 20 clocks; next phase 0 green is 30 clocks with walk[0]=1.
4. cross_btn[1] low exactly on the GRN(1) entry clock.
   - That green is 30 clocks; req[1] is clear afterwards.
5. reset_n low for 1 clock mid-YLW(1) with req[3] pending.
   - Next edge: all outputs 0.
   - Restart from INIT; phase 3 green is 20 clocks (request discarded).
6. PRESCALE=4, N_PHASES=2.
   - Green 80 clocks, yellow 12, clearance 8; period 200 clocks.
   - phase_idx toggles 0/1.
